// File: rtl/tow_referee.sv
// Tug-of-War round sequencer: start/countdown/play/done, press arbitration,
// signed rope position tracking and winner declaration.

module tow_edge #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_arm,
    input  logic [W-1:0] i_lvl,
    output logic [W-1:0] o_rise
);
    logic [W-1:0] r_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_d <= '0;
        else       r_d <= i_lvl;
    end

    // Rising edges are suppressed until the first post-reset cycle has loaded r_d,
    // so a button held through reset never counts as a press.
    assign o_rise = i_arm ? (i_lvl & ~r_d) : '0;
endmodule

module tow_referee #(
    parameter int COUNTDOWN_CYCLES = 8,
    parameter int WIN_POS          = 3,
    parameter int POS_W            = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_l_push,
    input  logic                    i_r_push,
    input  logic                    i_start,
    output logic signed [POS_W-1:0] o_pos,
    output logic [1:0]              o_state,
    output logic [1:0]              o_winner,
    output logic                    o_go
);
    localparam int CNT_W = $clog2(COUNTDOWN_CYCLES) + 1;
    localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(COUNTDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
    localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic signed [POS_W-1:0] POS_WIN  = POS_W'(WIN_POS);
    localparam logic signed [POS_W-1:0] POS_NWIN = -POS_W'(WIN_POS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [POS_W-1:0] r_pos;
    logic [1:0]              r_winner;
    logic                    r_go;
    logic                    r_arm;

    logic [2:0]              w_rise;
    logic                    w_lp, w_rp, w_sp;
    logic signed [POS_W-1:0] w_pos_nxt;

    tow_edge #(.W(3)) u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_arm  (r_arm),
        .i_lvl  ({i_start, i_r_push, i_l_push}),
        .o_rise (w_rise)
    );

    assign w_lp = w_rise[0];
    assign w_rp = w_rise[1];
    assign w_sp = w_rise[2];

    always_comb begin
        w_pos_nxt = r_pos;
        if (w_lp && !w_rp)      w_pos_nxt = r_pos - POS_ONE;
        else if (w_rp && !w_lp) w_pos_nxt = r_pos + POS_ONE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arm <= 1'b0;
        end else begin
            r_arm <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pos    <= '0;
            r_winner <= 2'b00;
            r_go     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pos    <= '0;
                    r_winner <= 2'b00;
                    r_go     <= 1'b0;
                    if (w_sp) begin
                        r_state <= S_COUNT;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_COUNT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
                    // A false start hands the round to the opponent.
                    if (w_lp && !w_rp) begin
                        r_state  <= S_DONE;
                        r_winner <= 2'b10;
                    end else if (w_rp && !w_lp) begin
                        r_state  <= S_DONE;
                        r_winner <= 2'b01;
                    end else if (w_lp && w_rp) begin
                        r_cnt <= CNT_LOAD;
                    end else if (r_cnt == '0) begin
                        r_state <= S_PLAY;
                        r_go    <= 1'b1;
                    end
                end
                S_PLAY: begin
                    r_pos <= w_pos_nxt;
                    if (w_pos_nxt == POS_NWIN) begin
                        r_state  <= S_DONE;
                        r_winner <= 2'b01;
                        r_go     <= 1'b0;
                    end else if (w_pos_nxt == POS_WIN) begin
                        r_state  <= S_DONE;
                        r_winner <= 2'b10;
                        r_go     <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_go <= 1'b0;
                    if (w_sp) begin
                        r_state  <= S_IDLE;
                        r_pos    <= '0;
                        r_winner <= 2'b00;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_pos    = r_pos;
    assign o_state  = r_state;
    assign o_winner = r_winner;
    assign o_go     = r_go;
endmodule

// File: tb/tb_tow_referee.sv
// Directed bench for tow_referee: reset, countdown, wins, arbitration, false starts, restart.

module tb_tow_referee;
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              l_push = 1'b0, r_push = 1'b0, start = 1'b0;
    logic signed [3:0] pos;
    logic [1:0]        state, winner;
    logic              go;
    int                checks = 0;
    int                errors = 0;

    tow_referee #(.COUNTDOWN_CYCLES(8), .WIN_POS(3), .POS_W(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_l_push (l_push),
        .i_r_push (r_push),
        .i_start  (start),
        .o_pos    (pos),
        .o_state  (state),
        .o_winner (winner),
        .o_go     (go)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after each edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        l_push = 0; r_push = 0; start = 0; rst = 1;
        tick(1);
        rst = 0;
        tick(1);
    endtask

    task automatic start_round();
        start = 1; tick(1); start = 0; tick(8);
    endtask

    task automatic test_reset();
        tick(1);
        l_push = 1; r_push = 1; start = 1; rst = 1;
        tick(2);
        checks++;
        if (state !== 2'd0 || pos !== 4'sd0 || winner !== 2'b00 || go !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals state=%0d pos=%0d winner=%b go=%b exp 0/0/00/0", state, pos, winner, go);
        end
        rst = 0;
        tick(3);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_held_btn state=%0d exp 0", state);
        end
        l_push = 0; r_push = 0; start = 0;
        tick(1);
    endtask

    task automatic test_countdown();
        do_reset();
        start = 1; tick(1); start = 0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state !== 2'd1 || go !== 1'b0) begin
                errors++;
                $display("FAIL count_pulse i=%0d state=%0d go=%b exp 1/0", i, state, go);
            end
            tick(1);
        end
        checks++;
        if (state !== 2'd2 || go !== 1'b1) begin
            errors++;
            $display("FAIL play_open state=%0d go=%b exp 2/1", state, go);
        end
        do_reset();
        start = 1; tick(1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state !== 2'd1) begin
                errors++;
                $display("FAIL count_held i=%0d state=%0d exp 1", i, state);
            end
            tick(1);
        end
        tick(11);
        checks++;
        if (state !== 2'd2 || go !== 1'b1 || pos !== 4'sd0) begin
            errors++;
            $display("FAIL start_held state=%0d go=%b pos=%0d exp 2/1/0", state, go, pos);
        end
        start = 0; tick(1);
    endtask

    task automatic test_right_win();
        logic signed [3:0] exp_pos [3];
        exp_pos[0] = 4'sd1; exp_pos[1] = 4'sd2; exp_pos[2] = 4'sd3;
        do_reset();
        start_round();
        for (int i = 0; i < 3; i++) begin
            r_push = 1; tick(1); r_push = 0;
            checks++;
            if (pos !== exp_pos[i]) begin
                errors++;
                $display("FAIL right_pos i=%0d pos=%0d exp %0d", i, pos, exp_pos[i]);
            end
            tick(1);
        end
        checks++;
        if (state !== 2'd3 || winner !== 2'b10 || go !== 1'b0) begin
            errors++;
            $display("FAIL right_win state=%0d winner=%b go=%b exp 3/10/0", state, winner, go);
        end
        r_push = 1; tick(1); r_push = 0; tick(1);
        l_push = 1; tick(1); l_push = 0; tick(1);
        checks++;
        if (state !== 2'd3 || winner !== 2'b10 || pos !== 4'sd3) begin
            errors++;
            $display("FAIL done_hold state=%0d winner=%b pos=%0d exp 3/10/3", state, winner, pos);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_round();
        l_push = 1; r_push = 1; tick(1); l_push = 0; r_push = 0;
        checks++;
        if (pos !== 4'sd0 || state !== 2'd2) begin
            errors++;
            $display("FAIL both_cancel pos=%0d state=%0d exp 0/2", pos, state);
        end
        tick(1);
        l_push = 1; tick(10); l_push = 0; tick(1);
        checks++;
        if (pos !== -4'sd1 || state !== 2'd2 || go !== 1'b1) begin
            errors++;
            $display("FAIL left_held pos=%0d state=%0d go=%b exp -1/2/1", pos, state, go);
        end
    endtask

    task automatic test_false_start();
        do_reset();
        start = 1; tick(1); start = 0;
        tick(3);
        r_push = 1; tick(1); r_push = 0;
        checks++;
        if (state !== 2'd3 || winner !== 2'b01 || pos !== 4'sd0 || go !== 1'b0) begin
            errors++;
            $display("FAIL false_right state=%0d winner=%b pos=%0d go=%b exp 3/01/0/0", state, winner, pos, go);
        end
        do_reset();
        start = 1; tick(1); start = 0;
        tick(3);
        l_push = 1; tick(1); l_push = 0;
        checks++;
        if (state !== 2'd3 || winner !== 2'b10) begin
            errors++;
            $display("FAIL false_left state=%0d winner=%b exp 3/10", state, winner);
        end
        do_reset();
        start = 1; tick(1); start = 0;
        tick(3);
        l_push = 1; r_push = 1; tick(1); l_push = 0; r_push = 0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state !== 2'd1) begin
                errors++;
                $display("FAIL both_reload i=%0d state=%0d exp 1", i, state);
            end
            tick(1);
        end
        checks++;
        if (state !== 2'd2 || go !== 1'b1) begin
            errors++;
            $display("FAIL reload_play state=%0d go=%b exp 2/1", state, go);
        end
    endtask

    task automatic test_reset_restart();
        do_reset();
        start_round();
        for (int i = 0; i < 2; i++) begin
            l_push = 1; tick(1); l_push = 0; tick(1);
        end
        checks++;
        if (pos !== -4'sd2) begin
            errors++;
            $display("FAIL left_two pos=%0d exp -2", pos);
        end
        rst = 1; tick(1); rst = 0;
        checks++;
        if (state !== 2'd0 || pos !== 4'sd0 || go !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset state=%0d pos=%0d go=%b exp 0/0/0", state, pos, go);
        end
        tick(1);
        start_round();
        for (int i = 0; i < 3; i++) begin
            l_push = 1; tick(1); l_push = 0; tick(1);
        end
        checks++;
        if (state !== 2'd3 || winner !== 2'b01 || pos !== -4'sd3) begin
            errors++;
            $display("FAIL left_win state=%0d winner=%b pos=%0d exp 3/01/-3", state, winner, pos);
        end
        start = 1; tick(1);
        checks++;
        if (state !== 2'd0 || pos !== 4'sd0 || winner !== 2'b00) begin
            errors++;
            $display("FAIL done_to_idle state=%0d pos=%0d winner=%b exp 0/0/00", state, pos, winner);
        end
        tick(3);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL held_no_relaunch state=%0d exp 0", state);
        end
        start = 0; tick(1);
        start = 1; tick(1); start = 0;
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL second_press state=%0d exp 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_right_win();
        test_simultaneous();
        test_false_start();
        test_reset_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
